// File: rtl/seg7_ctrl.sv
// Eight-digit multiplexed hex display controller with a small MMIO register block.
// All state advances on the falling edge of segclk; switrst clears everything asynchronously.
module seg7_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        segclk,
    input  logic        switrst,
    input  logic        segcs,
    input  logic        segwrite,
    input  logic        segread,
    input  logic [1:0]  segaddr,
    input  logic [15:0] segwdata,
    output logic [15:0] segrdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] ADDR_LO   = 2'b00;
    localparam logic [1:0] ADDR_CTRL = 2'b01;
    localparam logic [1:0] ADDR_HI   = 2'b10;

    localparam logic [15:0] CTRL_RST = 16'h00FF;

    logic [15:0]      data_lo;
    logic [15:0]      data_hi;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic             wr_en;
    logic             rd_en;
    logic [15:0]      rd_mux;
    logic [31:0]      digits;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_dec;
    logic             dig_on;
    logic             dp_on;
    logic [7:0]       nxt_an;
    logic [7:0]       nxt_out;

    // A simultaneous read is suppressed so the write always wins and segrdata holds.
    assign wr_en = segcs & segwrite;
    assign rd_en = segcs & segread & ~segwrite;

    always_comb begin
        rd_mux = '0;
        case (segaddr)
            ADDR_LO:   rd_mux = data_lo;
            ADDR_CTRL: rd_mux = ctrl;
            ADDR_HI:   rd_mux = data_hi;
            default:   rd_mux = '0;
        endcase
    end

    assign digits    = {data_hi, data_lo};
    assign cur_digit = digits[{idx, 2'b00} +: 4];
    assign dig_on    = ctrl[{1'b0, idx}];
    assign dp_on     = ctrl[{1'b1, idx}];

    // Active-low segment pattern, bit order g,f,e,d,c,b,a.
    always_comb begin
        seg_dec = 7'h7F;
        case (cur_digit)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_comb begin
        nxt_an  = '1;
        nxt_out = '1;
        if (dig_on) begin
            nxt_an  = ~(8'b1 << idx);
            nxt_out = {~dp_on, seg_dec};
        end
    end

    always_ff @(negedge segclk or posedge switrst) begin
        if (switrst) begin
            data_lo <= '0;
            data_hi <= '0;
            ctrl    <= CTRL_RST;
        end else if (wr_en) begin
            case (segaddr)
                ADDR_LO:   data_lo <= segwdata;
                ADDR_CTRL: ctrl    <= segwdata;
                ADDR_HI:   data_hi <= segwdata;
                default: ;
            endcase
        end
    end

    always_ff @(negedge segclk or posedge switrst) begin
        if (switrst) begin
            segrdata <= '0;
        end else if (rd_en) begin
            segrdata <= rd_mux;
        end
    end

    // Scan timing is independent of bus traffic; idx wraps naturally at 3 bits.
    always_ff @(negedge segclk or posedge switrst) begin
        if (switrst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(negedge segclk or posedge switrst) begin
        if (switrst) begin
            seg_an  <= '1;
            seg_out <= '1;
        end else begin
            seg_an  <= nxt_an;
            seg_out <= nxt_out;
        end
    end

endmodule

// File: tb/tb_seg7_ctrl.sv
// Randomized self-checking bench for seg7_ctrl; a reference model derives the scan
// position from the number of falling edges since reset and tracks the register file.
module tb_seg7_ctrl;

    localparam int SCAN_DIV = 4;

    logic        segclk;
    logic        switrst;
    logic        segcs;
    logic        segwrite;
    logic        segread;
    logic [1:0]  segaddr;
    logic [15:0] segwdata;
    logic [15:0] segrdata;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int checks = 0;
    int errors = 0;

    seg7_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .segclk   (segclk),
        .switrst  (switrst),
        .segcs    (segcs),
        .segwrite (segwrite),
        .segread  (segread),
        .segaddr  (segaddr),
        .segwdata (segwdata),
        .segrdata (segrdata),
        .seg_an   (seg_an),
        .seg_out  (seg_out)
    );

    initial segclk = 1'b1;
    always #5 segclk = ~segclk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_edges;
    logic [15:0] m_lo, m_hi, m_ctrl;
    logic [7:0]  exp_an, exp_out;
    logic [15:0] exp_rd;

    function automatic int digit_at(input int edges);
        return (edges / SCAN_DIV) % 8;
    endfunction

    function automatic logic [7:0] model_an(input int edges, input logic [15:0] c);
        int d;
        d = digit_at(edges);
        if (c[d]) return 8'hFF ^ (8'(1) << d);
        return 8'hFF;
    endfunction

    function automatic logic [7:0] model_out(input int edges, input logic [15:0] c,
                                             input logic [15:0] lo, input logic [15:0] hi);
        int d;
        int nib;
        d = digit_at(edges);
        if (!c[d]) return 8'hFF;
        nib = (d < 4) ? ((int'(lo) >> (4 * d)) & 15) : ((int'(hi) >> (4 * (d - 4))) & 15);
        return {~c[8 + d], seg_tab[nib]};
    endfunction

    always @(negedge segclk or posedge switrst) begin
        if (switrst) begin
            m_edges <= 0;
            m_lo    <= 16'h0000;
            m_hi    <= 16'h0000;
            m_ctrl  <= 16'h00FF;
            exp_an  <= 8'hFF;
            exp_out <= 8'hFF;
            exp_rd  <= 16'h0000;
        end else begin
            exp_an  <= model_an(m_edges, m_ctrl);
            exp_out <= model_out(m_edges, m_ctrl, m_lo, m_hi);
            m_edges <= m_edges + 1;
            if (segcs && segwrite) begin
                if (segaddr == 2'b00) m_lo <= segwdata;
                if (segaddr == 2'b10) m_hi <= segwdata;
                if (segaddr == 2'b01) m_ctrl <= segwdata;
            end else if (segcs && segread) begin
                case (segaddr)
                    2'b00:   exp_rd <= m_lo;
                    2'b10:   exp_rd <= m_hi;
                    2'b01:   exp_rd <= m_ctrl;
                    default: exp_rd <= 16'h0000;
                endcase
            end
        end
    end

    // Drive one bus cycle, then return 1 time unit after the following rising edge.
    task automatic cyc(input logic cs, input logic wr, input logic rd,
                       input logic [1:0] a, input logic [15:0] wd);
        segcs = cs; segwrite = wr; segread = rd; segaddr = a; segwdata = wd;
        @(negedge segclk);
        @(posedge segclk);
        #1;
    endtask

    task automatic test_reset;
        switrst = 1'b1;
        segcs = 0; segwrite = 0; segread = 0; segaddr = 0; segwdata = 0;
        repeat (3) @(posedge segclk);
        #1;
        checks++;
        if (seg_an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp FF", seg_an); end
        checks++;
        if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_out got %h exp FF", seg_out); end
        checks++;
        if (segrdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", segrdata); end
        switrst = 1'b0;
        cyc(0, 0, 0, 2'b00, 16'h0);
        checks++;
        if (seg_an !== 8'hFE) begin errors++; $display("FAIL first_an got %h exp FE", seg_an); end
        checks++;
        if (seg_out !== 8'hC0) begin errors++; $display("FAIL first_out got %h exp C0", seg_out); end
        cyc(1, 0, 1, 2'b01, 16'h0);
        checks++;
        if (segrdata !== 16'h00FF) begin errors++; $display("FAIL reset_ctrl got %h exp 00FF", segrdata); end
    endtask

    task automatic test_idle_scan;
        logic [7:0] want_an;
        for (int i = 0; i < 34; i++) begin
            cyc(0, 0, 0, 2'b00, 16'h0);
            want_an = 8'hFF ^ (8'(1) << digit_at(m_edges - 1));
            checks++;
            if (seg_an !== want_an || seg_out !== 8'hC0)
                begin errors++; $display("FAIL idle_scan an=%h out=%h exp %h/C0", seg_an, seg_out, want_an); end
        end
    endtask

    task automatic test_digits;
        cyc(1, 1, 0, 2'b00, 16'h1F08);
        cyc(1, 1, 0, 2'b10, 16'h0000);
        for (int i = 0; i < 36; i++) begin
            cyc(0, 0, 0, 2'b00, 16'h0);
            checks++;
            if (seg_an !== exp_an || seg_out !== exp_out)
                begin errors++; $display("FAIL digits an=%h out=%h exp %h/%h", seg_an, seg_out, exp_an, exp_out); end
        end
    endtask

    task automatic test_ctrl_mask;
        cyc(1, 1, 0, 2'b01, 16'h0105);
        for (int i = 0; i < 36; i++) begin
            cyc(0, 0, 0, 2'b00, 16'h0);
            checks++;
            if (seg_an !== exp_an || seg_out !== exp_out)
                begin errors++; $display("FAIL ctrl_mask an=%h out=%h exp %h/%h", seg_an, seg_out, exp_an, exp_out); end
            checks++;
            if (seg_an !== 8'hFF && !$onehot(~seg_an))
                begin errors++; $display("FAIL one_anode an=%h exp one or none low", seg_an); end
        end
    endtask

    task automatic test_unmapped;
        logic [15:0] want [4];
        want[0] = 16'h1F08; want[1] = 16'h0105; want[2] = 16'h0000; want[3] = 16'h0000;
        cyc(1, 1, 0, 2'b11, 16'hFFFF);
        for (int a = 0; a < 4; a++) begin
            cyc(1, 0, 1, 2'(a), 16'h0);
            checks++;
            if (segrdata !== want[a] || segrdata !== exp_rd)
                begin errors++; $display("FAIL read_addr%0d got %h exp %h", a, segrdata, want[a]); end
            checks++;
            if (seg_an !== exp_an || seg_out !== exp_out)
                begin errors++; $display("FAIL unmapped_disp an=%h out=%h exp %h/%h", seg_an, seg_out, exp_an, exp_out); end
        end
    endtask

    task automatic test_cs_low_and_rw;
        logic [15:0] held;
        held = segrdata;
        for (int a = 0; a < 4; a++) cyc(0, 1, 1, 2'(a), 16'hA5A5);
        checks++;
        if (segrdata !== held) begin errors++; $display("FAIL cs_low_rdata got %h exp %h", segrdata, held); end
        cyc(1, 0, 1, 2'b00, 16'h0);
        checks++;
        if (segrdata !== 16'h1F08) begin errors++; $display("FAIL cs_low_nowrite got %h exp 1F08", segrdata); end
        cyc(1, 1, 1, 2'b10, 16'h3C3C);
        checks++;
        if (segrdata !== 16'h1F08) begin errors++; $display("FAIL rw_hold got %h exp 1F08", segrdata); end
        cyc(1, 0, 1, 2'b10, 16'h0);
        checks++;
        if (segrdata !== 16'h3C3C) begin errors++; $display("FAIL rw_write got %h exp 3C3C", segrdata); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                2'($urandom_range(0, 3)), 16'($urandom));
            checks++;
            if (seg_an !== exp_an || seg_out !== exp_out || segrdata !== exp_rd)
                begin errors++; $display("FAIL random an=%h out=%h rd=%h exp %h/%h/%h",
                                         seg_an, seg_out, segrdata, exp_an, exp_out, exp_rd); end
        end
    endtask

    task automatic test_reset_mid;
        int guard;
        cyc(1, 1, 0, 2'b01, 16'hFFFF);
        guard = 0;
        while (!(digit_at(m_edges) == 5 && (m_edges % SCAN_DIV) == 2) && guard < 64) begin
            cyc(0, 0, 0, 2'b00, 16'h0);
            guard++;
        end
        checks++;
        if (guard >= 64) begin errors++; $display("FAIL reach_digit5 got guard %0d exp <64", guard); end
        switrst = 1'b1;
        #1;
        checks++;
        if (seg_an !== 8'hFF || seg_out !== 8'hFF)
            begin errors++; $display("FAIL mid_reset an=%h out=%h exp FF/FF", seg_an, seg_out); end
        #2;
        switrst = 1'b0;
        cyc(0, 0, 0, 2'b00, 16'h0);
        checks++;
        if (seg_an !== 8'hFE || seg_out !== 8'hC0)
            begin errors++; $display("FAIL restart an=%h out=%h exp FE/C0", seg_an, seg_out); end
        cyc(1, 0, 1, 2'b01, 16'h0);
        checks++;
        if (segrdata !== 16'h00FF) begin errors++; $display("FAIL post_reset_ctrl got %h exp 00FF", segrdata); end
        cyc(1, 0, 1, 2'b00, 16'h0);
        checks++;
        if (segrdata !== 16'h0000) begin errors++; $display("FAIL post_reset_lo got %h exp 0000", segrdata); end
        cyc(1, 0, 1, 2'b10, 16'h0);
        checks++;
        if (segrdata !== 16'h0000) begin errors++; $display("FAIL post_reset_hi got %h exp 0000", segrdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t exp finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_digits();
        test_ctrl_mask();
        test_unmapped();
        test_cs_low_and_rw();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
